// File: rtl/multdiv_issue.sv
// multdiv_issue: execute-stage issue/writeback sequencer for the multicycle
// multiplier/divider. It holds the pipeline while a mul/div is in flight,
// issues a single start pulse, waits for ready (or a timeout), and then
// presents a one-cycle writeback.
// Optional feature macro: MULTDIV_EXC_EN. When it is defined, an exception
// or a timeout redirects writeback to r30 with a status code.
module multdiv_issue #(
  parameter int unsigned TIMEOUT    = 40,
  parameter logic [31:0] MUL_STATUS = 32'd4,
  parameter logic [31:0] DIV_STATUS = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        x_is_mul,
  input  logic        x_is_div,
  input  logic [4:0]  x_rd,
  input  logic [31:0] x_op_a,
  input  logic [31:0] x_op_b,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_rdy,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int unsigned CNT_W  = 6;
  localparam logic [4:0]  EXC_RD = 5'd30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [4:0]         rd_q;
  logic [31:0]        res_q;
  logic               exc_q;
  logic               is_mul_q;

  logic               start;
  logic               timeout_hit;
  logic               exc_on_rdy;
  logic               exc_on_timeout;
  logic [4:0]         done_rd;
  logic [31:0]        done_data;

  // Exception source selection; without the feature the flag is constant 0.
`ifdef MULTDIV_EXC_EN
  assign exc_on_rdy     = md_exception;
  assign exc_on_timeout = 1'b1;
`else
  logic unused_exception;
  assign unused_exception = md_exception;
  assign exc_on_rdy       = 1'b0;
  assign exc_on_timeout   = 1'b0;
`endif

  assign start       = x_is_mul | x_is_div;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // Sequencer: latch operands, pulse the controller, wait, then write back.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_q         <= '0;
      res_q        <= '0;
      exc_q        <= 1'b0;
      is_mul_q     <= 1'b0;
      md_a         <= '0;
      md_b         <= '0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            md_a         <= x_op_a;
            md_b         <= x_op_b;
            rd_q         <= x_rd;
            is_mul_q     <= x_is_mul;
            md_ctrl_mult <= x_is_mul;
            md_ctrl_div  <= ~x_is_mul;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          md_ctrl_mult <= 1'b0;
          md_ctrl_div  <= 1'b0;
          cnt          <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (md_rdy) begin
            res_q <= md_result;
            exc_q <= exc_on_rdy;
            state <= DONE;
          end else if (timeout_hit) begin
            res_q <= '0;
            exc_q <= exc_on_timeout;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writeback target/data chosen from captured state.
  always_comb begin
    done_rd   = rd_q;
    done_data = res_q;
    if (exc_q) begin
      done_rd   = EXC_RD;
      done_data = is_mul_q ? MUL_STATUS : DIV_STATUS;
    end
  end

  // Outputs decoded purely from registers; stall also sees the X-stage start
  // so the instruction is frozen in the same cycle it is detected.
  assign busy     = (state != IDLE);
  assign wb_rd    = (state == DONE) ? done_rd : 5'd0;
  assign wb_data  = (state == DONE) ? done_data : 32'd0;
  assign wb_valid = (state == DONE) && (done_rd != 5'd0);
  assign stall    = reset && (((state == IDLE) && start) ||
                              (state == ISSUE) || (state == WAIT));

endmodule

// File: tb/tb_multdiv_issue.sv
// Self-checking bench for multdiv_issue. Each operation's expected timeline
// is derived from the cycle numbers in the block description (start in
// cycle 0, ready in cycle k, completion in k+1 or 2+TIMEOUT).
module tb_multdiv_issue;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        x_is_mul, x_is_div;
  logic [4:0]  x_rd;
  logic [31:0] x_op_a, x_op_b;
  logic [31:0] md_a, md_b;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_result;
  logic        md_exception, md_rdy;
  logic        stall, busy, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  multdiv_issue dut (
    .clock(clock), .reset(reset),
    .x_is_mul(x_is_mul), .x_is_div(x_is_div), .x_rd(x_rd),
    .x_op_a(x_op_a), .x_op_b(x_op_b),
    .md_a(md_a), .md_b(md_b),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_result(md_result), .md_exception(md_exception), .md_rdy(md_rdy),
    .stall(stall), .busy(busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  // One mul/div from start to one cycle past completion. k < 2 or k >= 2+TIMEOUT
  // means ready never arrives. Called just after a rising edge.
  task automatic run_op(input string name, input bit mul, input bit div,
                        input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int k, input bit exc,
                        input logic [31:0] res, input bit stray);
    bit          timeout = !(k >= 2 && k < 2 + TIMEOUT);
    int          done    = timeout ? 2 + TIMEOUT : k + 1;
    bit          exc_e;
    logic [4:0]  rd_e;
    logic [31:0] d_e;
    bit          v_e;
`ifdef MULTDIV_EXC_EN
    exc_e = timeout || exc;
`else
    exc_e = 1'b0;
`endif
    rd_e = exc_e ? 5'd30 : rd;
    d_e  = exc_e ? (mul ? 32'd4 : 32'd5) : (timeout ? 32'd0 : res);
    v_e  = (rd_e != 5'd0);
    for (int c = 0; c <= done + 1; c++) begin
      if (c == 0) begin
        x_is_mul = mul; x_is_div = div; x_rd = rd; x_op_a = a; x_op_b = b;
      end
      if (c == done + 1) begin
        x_is_mul = 1'b0; x_is_div = 1'b0;
        x_rd = 5'($urandom); x_op_a = $urandom; x_op_b = $urandom;
      end
      md_rdy       = (c == k) || (stray && c == 1);
      md_result    = (c == k) ? res : $urandom;
      md_exception = (c == k) ? exc : 1'($urandom);
      @(negedge clock);
      checks++;
      if (stall !== (c < done)) begin
        failures++;
        $display("FAIL %s stall c=%0d got %b exp %b", name, c, stall, (c < done));
      end
      checks++;
      if (busy !== (c >= 1 && c <= done)) begin
        failures++;
        $display("FAIL %s busy c=%0d got %b", name, c, busy);
      end
      checks++;
      if (md_ctrl_mult !== (c == 1 && mul) || md_ctrl_div !== (c == 1 && !mul)) begin
        failures++;
        $display("FAIL %s ctrl c=%0d got mult=%b div=%b exp mul=%b", name, c,
                 md_ctrl_mult, md_ctrl_div, mul);
      end
      if (c >= 1 && c <= done + 1) begin
        checks++;
        if (md_a !== a || md_b !== b) begin
          failures++;
          $display("FAIL %s operands c=%0d got %h %h exp %h %h", name, c, md_a, md_b, a, b);
        end
      end
      checks++;
      if (wb_valid !== (c == done && v_e) ||
          wb_rd !== ((c == done) ? rd_e : 5'd0) ||
          wb_data !== ((c == done) ? d_e : 32'd0)) begin
        failures++;
        $display("FAIL %s wb c=%0d got v=%b rd=%0d d=%h exp v=%b rd=%0d d=%h",
                 name, c, wb_valid, wb_rd, wb_data, (c == done && v_e),
                 (c == done) ? rd_e : 5'd0, (c == done) ? d_e : 32'd0);
      end
      @(posedge clock); #1;
    end
    md_rdy = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    x_is_mul = 1'b0; x_is_div = 1'b0; x_rd = '0; x_op_a = '0; x_op_b = '0;
    md_result = '0; md_exception = 1'b0; md_rdy = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({md_a, md_b, md_ctrl_mult, md_ctrl_div, stall, busy, wb_valid, wb_rd, wb_data} !== '0) begin
      failures++;
      $display("FAIL reset_state outputs not zero busy=%b stall=%b wb_valid=%b", busy, stall, wb_valid);
    end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_wait;
    x_is_mul = 1'b1; x_is_div = 1'b0; x_rd = 5'd9; x_op_a = 32'd11; x_op_b = 32'd13;
    repeat (6) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1;
    checks++;
    if ({md_a, md_b, md_ctrl_mult, md_ctrl_div, stall, busy, wb_valid, wb_rd, wb_data} !== '0) begin
      failures++;
      $display("FAIL reset_mid_wait outputs got busy=%b stall=%b md_a=%h exp all zero", busy, stall, md_a);
    end
    x_is_mul = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      md_rdy = 1'b1; md_result = 32'hdead_beef;
      @(negedge clock);
      checks++;
      if (wb_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_drop c=%0d got wb_valid=%b busy=%b exp 0 0", c, wb_valid, busy);
      end
      @(posedge clock); #1;
    end
    md_rdy = 1'b0;
  endtask

  task automatic test_directed;
    run_op("mul_7x6", 1'b1, 1'b0, 5'd3, 32'd7, 32'd6, 20, 1'b0, 32'd42, 1'b0);
    run_op("div_exc", 1'b0, 1'b1, 5'd12, 32'd100, 32'd0, 5, 1'b1, 32'h1234_5678, 1'b0);
    run_op("mul_timeout", 1'b1, 1'b0, 5'd7, 32'd3, 32'd9, -1, 1'b0, 32'd0, 1'b0);
    run_op("div_timeout", 1'b0, 1'b1, 5'd8, 32'd3, 32'd9, -1, 1'b0, 32'd0, 1'b0);
    run_op("both_set", 1'b1, 1'b1, 5'd4, 32'd2, 32'd5, 2, 1'b0, 32'd10, 1'b0);
    run_op("rd_zero", 1'b1, 1'b0, 5'd0, 32'd2, 32'd5, 3, 1'b0, 32'd10, 1'b0);
    run_op("last_wait", 1'b0, 1'b1, 5'd21, 32'd9, 32'd3, 1 + TIMEOUT, 1'b0, 32'd3, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_op("b2b_first", 1'b1, 1'b0, 5'd5, 32'd4, 32'd4, 2, 1'b0, 32'd16, 1'b1);
    run_op("b2b_second", 1'b1, 1'b0, 5'd6, 32'd5, 32'd5, 3, 1'b0, 32'd25, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      bit mul = 1'($urandom);
      int k   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(2, 30));
      run_op("random", mul, !mul || 1'($urandom), 5'($urandom), $urandom, $urandom,
             k, 1'($urandom), $urandom, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
